midi_uart_tx: RTL and testbench
===============================

MIDI_UART_TX -- requirements
Module: midi_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, reg_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO depth; SHALL be a power of 2 and at least 2.
REQ-004 SHALL have parameter RUN_STATUS, default 1; when 1, the running-status filter is enabled.
REQ-005 SHALL have port reg_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_reg, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port tx_data, input, 8 bits: MIDI byte offered for transmission.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, output, 1 bit: FIFO can accept a byte.
REQ-010 SHALL have port midi_txd, output, 1 bit: serial line, true polarity, idle high.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-012 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of bytes held in the FIFO.

Function
REQ-013 SHALL accept a byte on each rising reg_clk edge where tx_valid and tx_ready are both 1.
- tx_ready = (fifo_level < FIFO_DEPTH), combinational from registered state.
REQ-014 SHALL derive DIV = CLK_HZ/BAUD (integer division); every bit SHALL last exactly DIV cycles.
REQ-015 SHALL send each frame as 10 bits, LSB first: start bit 0, data[0] through data[7], one stop bit 1.
REQ-016 SHALL implement states IDLE, START, DATA, STOP.
- IDLE to START: when FIFO is non-empty; pops the head byte.
- START to DATA: after DIV cycles.
- DATA to STOP: after 8 bit periods, tracked by a 3-bit index.
- STOP to START: if FIFO is non-empty, popping on the same edge with no idle gap.
- STOP to IDLE: otherwise.
REQ-017 SHALL meet this latency: a byte accepted into an empty FIFO at edge t, with the FSM in IDLE, drives midi_txd low from edge t+2.
REQ-018 SHALL apply the running-status filter at pop time when RUN_STATUS=1. A byte of 0x80-0xEF equal to the last sent status SHALL be discarded, not transmitted, and the next FIFO byte SHALL be considered in the same cycle's pop path (the following cycle).
REQ-019 SHALL update last_status as follows:
- a sent byte of 0x80-0xEF loads last_status;
- a sent byte of 0xF0-0xF7 clears it (invalid);
- 0xF8-0xFF bytes and data bytes leave it unchanged.
REQ-020 SHALL handle simultaneous push and pop by leaving fifo_level unchanged; push when full SHALL be impossible (tx_ready=0), and pop when empty SHALL not occur.
REQ-021 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-022 SHALL hold midi_txd registered (glitch-free); it SHALL be 1 in IDLE and STOP.

Reset
REQ-023 SHALL, on reset_reg=1 at a reg_clk edge, set the following, aborting any frame mid-bit:
- FSM to IDLE;
- midi_txd=1;
- fifo_level=0 with pointers at 0;
- tx_ready=1;
- busy=0;
- last_status invalid;
- baud counter and bit index to 0.
REQ-024 SHALL ignore tx_valid during the cycles reset_reg is 1.

Structure
REQ-025 SHALL place the state enum (IDLE, START, DATA, STOP) and the MIDI status-class constants (0x80, 0xF0, 0xF8) in shared package midi_pkg.
REQ-026 SHALL implement the FIFO as sub-module midi_byte_fifo (synchronous, first-word-fall-through, with level output); the FSM, baud counter and filter SHALL reside in midi_uart_tx.

Verification (CLK_HZ=3125000, BAUD=31250, so DIV=100)
REQ-027 SHALL cover single byte: push 0x90 into an idle block.
- midi_txd is low from t+2 for 100 cycles.
- Bits follow 0,0,0,0,1,0,0,1 at 100-cycle spacing.
- Stop bit is high for 100 cycles.
- busy drops right after the stop bit.
REQ-028 SHALL cover back-to-back frames: push 0x90,0x3C,0x64 in consecutive cycles.
- Three contiguous frames, 3000 cycles total, with no idle gap.
REQ-029 SHALL cover running status: push 0x90,0x3C,0x64,0x90,0x3E,0x00.
- Exactly 5 bytes go on the line; the second 0x90 is dropped.
- Pushing 0xF8 between the messages does not break suppression.
- Pushing 0xF0 between them forces the second 0x90 to be sent.
REQ-030 SHALL cover full FIFO: push 17 bytes while the first frame is busy (FIFO_DEPTH=16).
- tx_ready goes 0 at fifo_level=16.
- No byte is lost and order is preserved.
- Pointer wrap is exercised with 40 bytes.
REQ-031 SHALL cover reset mid-frame: assert reset_reg in the DATA state, bit 4.
- Next cycle: midi_txd=1, fifo_level=0, busy=0.
- After release, a new 0x90 is sent in full, because last_status was cleared.

Source files
------------

// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI UART transmitter:
//   - tx_state_e         : serializer FSM states (IDLE, START, DATA, STOP)
//   - STATUS_BASE etc.   : boundaries of the MIDI byte classes
//   - is_channel_status  : 0x80-0xEF, the bytes subject to running status
//   - is_sys_common      : 0xF0-0xF7, the bytes that cancel running status
// -----------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [7:0] STATUS_BASE   = 8'h80;  // first channel status byte
    localparam logic [7:0] SYSCOM_BASE   = 8'hF0;  // first system common byte
    localparam logic [7:0] REALTIME_BASE = 8'hF8;  // first system real-time byte

    function automatic logic is_channel_status(input logic [7:0] b);
        return (b >= STATUS_BASE) && (b < SYSCOM_BASE);
    endfunction

    function automatic logic is_sys_common(input logic [7:0] b);
        return (b >= SYSCOM_BASE) && (b < REALTIME_BASE);
    endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// -----------------------------------------------------------------------------
// midi_byte_fifo
// Synchronous first-word-fall-through byte FIFO with an occupancy output.
//   reg_clk   : clock
//   reset_reg : synchronous active-high reset (pointers and level to 0)
//   push      : write wdata this edge (ignored when full)
//   wdata     : byte to store
//   pop       : discard the head byte this edge (ignored when empty)
//   rdata     : current head byte, valid whenever level != 0
//   level     : number of bytes held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module midi_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          reg_clk,
    input  logic          reset_reg,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic [LW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (level != LW'(DEPTH));
    assign do_pop  = pop  && (level != '0);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge, whatever the block order.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;  // idle, or push and pop together
            endcase
        end
    end

    // NOTE: the storage array has no reset; a slot is only ever read after it
    // has been written, and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge reg_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/midi_uart_tx.sv
// -----------------------------------------------------------------------------
// midi_uart_tx
// MIDI byte transmitter: FIFO, running-status filter and 8N1 serializer.
//   reg_clk    : single clock, CLK_HZ
//   reset_reg  : synchronous active-high reset, aborts any frame
//   tx_data    : byte offered for transmission
//   tx_valid   : tx_data valid; accepted when tx_ready is also 1
//   tx_ready   : FIFO has room
//   midi_txd   : registered serial line, idle high, LSB first
//   busy       : frame on the line or bytes waiting in the FIFO
//   fifo_level : bytes held in the FIFO
// Every bit lasts DIV = CLK_HZ/BAUD cycles. midi_txd is registered from the
// FSM state, so the line trails the state by exactly one cycle.
// -----------------------------------------------------------------------------
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 16,
    parameter int RUN_STATUS = 1
) (
    input  logic                          reg_clk,
    input  logic                          reset_reg,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          midi_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int  DIV   = CLK_HZ / BAUD;
    localparam int  CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int  LW    = $clog2(FIFO_DEPTH) + 1;
    localparam bit  RS_EN = (RUN_STATUS != 0);

    tx_state_e     state;
    tx_state_e     state_next;
    logic [7:0]    fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_nonempty;
    logic          load;          // head byte is popped and starts a frame
    logic          head_dup;      // head byte is a redundant running status
    logic          bit_tick;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    last_status;
    logic          status_valid;
    logic          line_active;   // state was non-IDLE last cycle

    assign tx_ready      = (fifo_level < LW'(FIFO_DEPTH));
    assign fifo_push     = tx_valid && tx_ready && !reset_reg;
    assign fifo_nonempty = (fifo_level != '0);
    assign bit_tick      = (baud_cnt == CW'(DIV - 1));
    assign head_dup      = RS_EN && status_valid && is_channel_status(fifo_head)
                           && (fifo_head == last_status);

    // line_active stretches busy over the cycle by which midi_txd lags the
    // state, so busy falls exactly when the stop bit ends on the line.
    assign busy = line_active || (state != IDLE) || fifo_nonempty;

    midi_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .reg_clk   (reg_clk),
        .reset_reg (reset_reg),
        .push      (fifo_push),
        .wdata     (tx_data),
        .pop       (fifo_pop),
        .rdata     (fifo_head),
        .level     (fifo_level)
    );

    always_ff @(posedge reg_clk) begin
        if (reset_reg) state <= IDLE;
        else           state <= state_next;
    end

    // A redundant status byte is popped without loading; the byte behind it
    // is then considered from IDLE on the following cycle.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    fifo_pop = 1'b1;
                    if (!head_dup) begin
                        load       = 1'b1;
                        state_next = START;
                    end
                end
            end
            START: begin
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    if (fifo_nonempty) begin
                        fifo_pop = 1'b1;
                        if (!head_dup) begin
                            load       = 1'b1;
                            state_next = START;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            last_status  <= '0;
            status_valid <= 1'b0;
            midi_txd     <= 1'b1;
            line_active  <= 1'b0;
        end else begin
            line_active <= (state != IDLE);

            if (load || (state == IDLE) || bit_tick) baud_cnt <= '0;
            else                                     baud_cnt <= baud_cnt + CW'(1);

            if (load)                          bit_idx <= '0;
            else if ((state == DATA) && bit_tick) bit_idx <= bit_idx + 3'd1;

            // Running status tracks what actually goes on the line.
            if (load) begin
                shreg <= fifo_head;
                if (is_channel_status(fifo_head)) begin
                    last_status  <= fifo_head;
                    status_valid <= 1'b1;
                end else if (is_sys_common(fifo_head)) begin
                    status_valid <= 1'b0;
                end
            end

            case (state)
                START:   midi_txd <= 1'b0;
                DATA:    midi_txd <= shreg[bit_idx];
                default: midi_txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_midi_uart_tx
// Self-checking bench for midi_uart_tx at DIV = 100. A line receiver decodes
// every frame at mid-bit and compares it with the head of a scoreboard queue
// filled with the bytes expected on the line.
// -----------------------------------------------------------------------------
module tb_midi_uart_tx;

    localparam int CLK_HZ     = 3125000;
    localparam int BAUD       = 31250;
    localparam int DIV        = 100;
    localparam int FIFO_DEPTH = 16;
    localparam int LW         = 5;
    localparam int FRAME      = 10 * DIV;

    logic          reg_clk   = 1'b0;
    logic          reset_reg = 1'b1;
    logic [7:0]    tx_data   = 8'h00;
    logic          tx_valid  = 1'b0;
    logic          tx_ready;
    logic          midi_txd;
    logic          busy;
    logic [LW-1:0] fifo_level;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rx_frames = 0;
    int         last_push_cyc = 0;
    bit         rx_enable = 1'b1;
    logic [7:0] sb_q [$];

    typedef struct {
        int               n_in;
        logic [0:7][7:0]  din;
        int               n_out;
        logic [0:7][7:0]  dout;
    } rs_vec_t;

    rs_vec_t vecs [4];

    midi_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RUN_STATUS (1)
    ) dut (
        .reg_clk    (reg_clk),
        .reset_reg  (reset_reg),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .midi_txd   (midi_txd),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 reg_clk = ~reg_clk;
    always @(posedge reg_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Return #1 after rising edge number n.
    task automatic at_edge(input int n);
        while (cyc < n) begin
            @(posedge reg_clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        @(negedge reg_clk);
        while (!tx_ready && n < 2000) begin
            @(negedge reg_clk);
            n++;
        end
        check("push_ready", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge reg_clk);
        #1;
        tx_valid      = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic apply_reset();
        @(negedge reg_clk);
        reset_reg = 1'b1;
        tx_valid  = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge reg_clk);
        reset_reg = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < limit) begin
            @(posedge reg_clk);
            #1;
            n++;
        end
        check("drain_done", (sb_q.size() == 0) && !busy, 1'b1);
    endtask

    // Line receiver: start edge seen on a falling clock, then samples at bit centres.
    initial begin : rx_proc
        logic [7:0] rx_byte;
        logic [7:0] exp_b;
        logic       start_ok;
        logic       stop_ok;
        bit         en_at_start;
        forever begin
            @(negedge reg_clk);
            if (midi_txd === 1'b0 && !reset_reg) begin
                en_at_start = rx_enable;
                repeat (DIV / 2 - 1) @(negedge reg_clk);
                start_ok = (midi_txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge reg_clk);
                    rx_byte[i] = midi_txd;
                end
                repeat (DIV) @(negedge reg_clk);
                stop_ok = (midi_txd === 1'b1);
                if (en_at_start && rx_enable) begin
                    check("rx_start_bit", start_ok, 1'b1);
                    check("rx_stop_bit", stop_ok, 1'b1);
                    check("rx_expected_pending", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        exp_b = sb_q.pop_front();
                        check("rx_byte", rx_byte, exp_b);
                    end
                    rx_frames++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int          t;
        int          base;
        logic [9:0]  line_bits;
        logic [7:0]  fill [40];

        // Running-status vectors: pushed bytes and the bytes that must reach the line.
        vecs[0].n_in  = 6;
        vecs[0].din   = {8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h00, 8'h00, 8'h00};
        vecs[0].n_out = 5;
        vecs[0].dout  = {8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].n_in  = 7;
        vecs[1].din   = {8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3E, 8'h00, 8'h00};
        vecs[1].n_out = 6;
        vecs[1].dout  = {8'h90, 8'h3C, 8'h64, 8'hF8, 8'h3E, 8'h00, 8'h00, 8'h00};
        vecs[2].n_in  = 7;
        vecs[2].din   = {8'h90, 8'h3C, 8'h64, 8'hF0, 8'h90, 8'h3E, 8'h00, 8'h00};
        vecs[2].n_out = 7;
        vecs[2].dout  = {8'h90, 8'h3C, 8'h64, 8'hF0, 8'h90, 8'h3E, 8'h00, 8'h00};
        vecs[3].n_in  = 8;
        vecs[3].din   = {8'h90, 8'h3C, 8'h40, 8'h80, 8'h3C, 8'h40, 8'h80, 8'h3C};
        vecs[3].n_out = 7;
        vecs[3].dout  = {8'h90, 8'h3C, 8'h40, 8'h80, 8'h3C, 8'h40, 8'h3C, 8'h00};

        // Reset state
        apply_reset();
        check("reset_txd", midi_txd, 1'b1);
        check("reset_ready", tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_level", fifo_level, 0);

        // Single byte 0x90: start, LSB-first data, stop; each bit exactly DIV cycles.
        apply_reset();
        base = rx_frames;
        sb_q.push_back(8'h90);
        push_byte(8'h90);
        t = last_push_cyc;
        at_edge(t + 1);
        check("latency_t1_high", midi_txd, 1'b1);
        line_bits = 10'b1_1001_0000_0;  // index 0 = start bit, 9 = stop bit
        for (int k = 0; k < 10; k++) begin
            at_edge(t + 2 + DIV * k);
            check("bit_first_cycle", midi_txd, line_bits[k]);
            at_edge(t + 1 + DIV * (k + 1));
            check("bit_last_cycle", midi_txd, line_bits[k]);
        end
        check("busy_during_stop", busy, 1'b1);
        at_edge(t + 2 + FRAME);
        check("busy_after_stop", busy, 1'b0);
        check("idle_after_stop", midi_txd, 1'b1);
        wait_drain(2000);
        check("single_frame_count", rx_frames - base, 1);

        // Back-to-back: three contiguous frames, no idle gap.
        apply_reset();
        base = rx_frames;
        sb_q.push_back(8'h90);
        sb_q.push_back(8'h3C);
        sb_q.push_back(8'h64);
        push_byte(8'h90);
        t = last_push_cyc;
        push_byte(8'h3C);
        push_byte(8'h64);
        at_edge(t + 1 + FRAME);
        check("b2b_stop0_last", midi_txd, 1'b1);
        at_edge(t + 2 + FRAME);
        check("b2b_start1", midi_txd, 1'b0);
        at_edge(t + 1 + 2 * FRAME);
        check("b2b_stop1_last", midi_txd, 1'b1);
        at_edge(t + 2 + 2 * FRAME);
        check("b2b_start2", midi_txd, 1'b0);
        at_edge(t + 1 + 3 * FRAME);
        check("b2b_busy_end", busy, 1'b1);
        at_edge(t + 2 + 3 * FRAME);
        check("b2b_idle", busy, 1'b0);
        wait_drain(2000);
        check("b2b_frame_count", rx_frames - base, 3);

        // Running-status filter vectors.
        for (int v = 0; v < 4; v++) begin
            apply_reset();
            base = rx_frames;
            for (int i = 0; i < vecs[v].n_out; i++) sb_q.push_back(vecs[v].dout[i]);
            for (int i = 0; i < vecs[v].n_in; i++) push_byte(vecs[v].din[i]);
            wait_drain(12 * FRAME);
            check("rs_frame_count", rx_frames - base, vecs[v].n_out);
        end

        // Full FIFO and pointer wrap with 40 data bytes.
        apply_reset();
        base = rx_frames;
        for (int i = 0; i < 40; i++) begin
            fill[i] = 8'((i * 7 + 1) & 8'h7F);
            sb_q.push_back(fill[i]);
        end
        for (int i = 0; i < 17; i++) push_byte(fill[i]);
        check("full_level", fifo_level, FIFO_DEPTH);
        check("full_not_ready", tx_ready, 1'b0);
        for (int i = 17; i < 40; i++) push_byte(fill[i]);
        wait_drain(45 * FRAME);
        check("full_frame_count", rx_frames - base, 40);

        // Reset in DATA state, bit 4, with a byte still queued.
        apply_reset();
        rx_enable = 1'b0;
        push_byte(8'h90);
        t = last_push_cyc;
        push_byte(8'h3C);
        at_edge(t + 550);
        check("pre_reset_level", fifo_level, 1);
        @(negedge reg_clk);
        reset_reg = 1'b1;
        tx_data   = 8'h55;
        tx_valid  = 1'b1;
        @(posedge reg_clk);
        #1;
        check("midreset_txd", midi_txd, 1'b1);
        check("midreset_level", fifo_level, 0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_ready", tx_ready, 1'b1);
        @(posedge reg_clk);
        #1;
        check("reset_ignores_valid", fifo_level, 0);
        @(negedge reg_clk);
        reset_reg = 1'b0;
        tx_valid  = 1'b0;
        repeat (1200) @(posedge reg_clk);
        #1;
        check("post_reset_txd", midi_txd, 1'b1);
        check("post_reset_busy", busy, 1'b0);
        rx_enable = 1'b1;
        base = rx_frames;
        sb_q.push_back(8'h90);
        push_byte(8'h90);
        wait_drain(2 * FRAME);
        check("post_reset_frame_count", rx_frames - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
